serial_adder_ctrl: RTL

Bit-serial add/subtract unit that time-shares a single one-bit full-adder cell across all operand bits. A small FSM, a bit counter and a carry flip-flop feed the cell one bit per cycle. It sits beside the arithmetic library as the low-area alternative to a ripple-carry adder, for datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake lets a host sequencer issue one operation at a time.

---
 rtl/serial_adder_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell reused for every operand bit,
// sequenced LSB first by a small FSM with a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           sum;
  logic           cout;
  logic           last;

  always_comb begin
    sum  = a_sr[0] ^ b_sr[0] ^ carry;
    cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    last = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Subtract is A + ~B + 1: the +1 enters as the seeded carry.
  // The carry FF on the MSB cycle is the carry into the MSB, so overflow
  // is taken directly from it and the cell carry on that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= op ? ~B : B;
            carry <= op;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= {sum, r_sr[WIDTH-1:1]};
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result    <= {sum, r_sr[WIDTH-1:1]};
            carry_out <= cout;
            overflow  <= carry ^ cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
